// File: rtl/clk_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_seq_pkg
// Purpose  : Shared types and constants for the clock-enable / reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package clk_seq_pkg;

    localparam int unsigned c_lock_lost_w = 8;
    localparam int unsigned c_state_w     = 2;

    typedef enum logic [c_state_w-1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic logic [c_lock_lost_w-1:0] sat_inc(
        input logic [c_lock_lost_w-1:0] value
    );
        return (value == {c_lock_lost_w{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ce_divider.sv
`default_nettype none
// ============================================================================
// Module   : ce_divider
// Purpose  : Free-running divider producing pixel, inverted-phase pixel and
//            CPU clock enables as registered single-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module ce_divider #(
    parameter int unsigned CE_DIV = 8
) (
    input  logic clk_sys,
    input  logic run,
    input  logic clear,
    output logic ce_pix,
    output logic ce_pix_n,
    output logic ce_cpu
);

    localparam int unsigned           c_div_w    = $clog2(CE_DIV);
    localparam logic [c_div_w-1:0]    c_div_last = c_div_w'(CE_DIV - 1);
    localparam logic [c_div_w-1:0]    c_div_half = c_div_w'(CE_DIV / 2 - 1);

    logic [c_div_w-1:0] r_div;
    logic               r_cpu_phase;
    logic               r_ce_pix;
    logic               r_ce_pix_n;
    logic               r_ce_cpu;
    logic               w_div_last;

    assign w_div_last = (r_div == c_div_last);

    // Clearing the CPU phase makes the first pixel enable after a restart a
    // non-CPU edge, so the CPU enable always lands on the second one.
    always_ff @(posedge clk_sys) begin
        if (clear) begin
            r_div       <= '0;
            r_cpu_phase <= 1'b0;
            r_ce_pix    <= 1'b0;
            r_ce_pix_n  <= 1'b0;
            r_ce_cpu    <= 1'b0;
        end else if (run) begin
            r_div      <= w_div_last ? '0 : r_div + 1'b1;
            r_ce_pix   <= w_div_last;
            r_ce_pix_n <= (r_div == c_div_half);
            r_ce_cpu   <= w_div_last && r_cpu_phase;
            if (w_div_last) begin
                r_cpu_phase <= ~r_cpu_phase;
            end
        end else begin
            r_ce_pix   <= 1'b0;
            r_ce_pix_n <= 1'b0;
            r_ce_cpu   <= 1'b0;
        end
    end

    assign ce_pix   = r_ce_pix;
    assign ce_pix_n = r_ce_pix_n;
    assign ce_cpu   = r_ce_cpu;

endmodule
`default_nettype wire

// File: rtl/clk_ce_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : clk_ce_reset_seq
// Purpose  : Sequences core reset release after PLL lock and drives the core
//            clock enables; counts lock losses once the core is coming up.
// Revision : 1.0 - initial release
// ============================================================================
module clk_ce_reset_seq
    import clk_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 4096,
    parameter int unsigned CE_DIV             = 8,
    parameter int unsigned HOLD_CYCLES        = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     pll_locked,
    output logic                     core_reset,
    output logic                     ce_pix,
    output logic                     ce_pix_n,
    output logic                     ce_cpu,
    output logic                     ready,
    output logic [c_lock_lost_w-1:0] lock_lost_cnt
);

    localparam int unsigned        c_stab_w    = $clog2(LOCK_STABLE_CYCLES);
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(LOCK_STABLE_CYCLES - 1);
    localparam int unsigned        c_hold_w    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    logic                     r_sync_meta;
    logic                     r_locked_s;
    seq_state_t               r_state;
    seq_state_t               w_next_state;
    logic [c_stab_w-1:0]      r_stab_cnt;
    logic [c_hold_w-1:0]      r_hold_cnt;
    logic [c_lock_lost_w-1:0] r_lock_lost_cnt;
    logic                     r_core_reset;
    logic                     r_ready;
    logic                     w_lock_lost;
    logic                     w_enter_release;
    logic                     w_div_run;
    logic                     w_div_clear;
    logic                     w_ce_pix;
    logic                     w_ce_pix_n;
    logic                     w_ce_cpu;

    always_comb begin
        w_next_state = r_state;
        w_lock_lost  = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_next_state = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!r_locked_s) begin
                    w_next_state = WAIT_LOCK;
                end else if (r_stab_cnt == c_stab_last) begin
                    w_next_state = RELEASE;
                end
            end
            RELEASE: begin
                // Lock loss outranks completion of the hold period.
                if (!r_locked_s) begin
                    w_next_state = WAIT_LOCK;
                    w_lock_lost  = 1'b1;
                end else if (w_ce_pix && (r_hold_cnt == c_hold_last)) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (!r_locked_s) begin
                    w_next_state = WAIT_LOCK;
                    w_lock_lost  = 1'b1;
                end
            end
            default: w_next_state = WAIT_LOCK;
        endcase
    end

    assign w_enter_release = (r_state == STABILIZE) && (w_next_state == RELEASE);
    // Gating on the synchronized lock stops the enables on the same edge that
    // returns the core to reset.
    assign w_div_run   = ((r_state == RELEASE) || (r_state == RUN)) && r_locked_s;
    assign w_div_clear = reset || w_enter_release;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync_meta     <= 1'b0;
            r_locked_s      <= 1'b0;
            r_state         <= WAIT_LOCK;
            r_stab_cnt      <= '0;
            r_hold_cnt      <= '0;
            r_lock_lost_cnt <= '0;
            r_core_reset    <= 1'b1;
            r_ready         <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_locked_s  <= r_sync_meta;
            r_state     <= w_next_state;

            if ((r_state == STABILIZE) && (w_next_state == STABILIZE)) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end else begin
                r_stab_cnt <= '0;
            end

            if (w_enter_release) begin
                r_hold_cnt <= '0;
            end else if ((r_state == RELEASE) && w_ce_pix) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (w_lock_lost) begin
                r_lock_lost_cnt <= sat_inc(r_lock_lost_cnt);
            end

            r_core_reset <= (w_next_state != RUN);
            r_ready      <= (w_next_state == RUN);
        end
    end

    ce_divider #(
        .CE_DIV (CE_DIV)
    ) u_ce_divider (
        .clk_sys  (clk_sys),
        .run      (w_div_run),
        .clear    (w_div_clear),
        .ce_pix   (w_ce_pix),
        .ce_pix_n (w_ce_pix_n),
        .ce_cpu   (w_ce_cpu)
    );

    assign core_reset    = r_core_reset;
    assign ready         = r_ready;
    assign ce_pix        = w_ce_pix;
    assign ce_pix_n      = w_ce_pix_n;
    assign ce_cpu        = w_ce_cpu;
    assign lock_lost_cnt = r_lock_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_ce_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_ce_reset_seq
// Purpose  : Self-checking bench for clk_ce_reset_seq against a lock-run-length
//            model, plus directed literal checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_ce_reset_seq;
    import clk_seq_pkg::*;

    localparam int LOCK_STABLE_CYCLES = 16;
    localparam int CE_DIV             = 8;
    localparam int HOLD_CYCLES        = 4;
    localparam int c_rel_run          = LOCK_STABLE_CYCLES + 1;
    localparam int c_ready_at         = HOLD_CYCLES * CE_DIV + 1;

    logic       clk_sys    = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       core_reset;
    logic       ce_pix;
    logic       ce_pix_n;
    logic       ce_cpu;
    logic       ready;
    logic [7:0] lock_lost_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    clk_ce_reset_seq #(
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .CE_DIV             (CE_DIV),
        .HOLD_CYCLES        (HOLD_CYCLES)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .core_reset    (core_reset),
        .ce_pix        (ce_pix),
        .ce_pix_n      (ce_pix_n),
        .ce_cpu        (ce_cpu),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: outputs follow from how long the synchronized lock has been held.
    bit m_valid = 0;
    bit m_s1 = 0, m_s2 = 0;
    int m_run = 0;
    int m_lost = 0;
    bit m_core_reset = 1, m_ce_pix = 0, m_ce_pix_n = 0, m_ce_cpu = 0, m_ready = 0;

    always @(posedge clk_sys) begin
        int s;
        if (reset) begin
            m_valid = 1;
            m_s1 = 0; m_s2 = 0; m_run = 0; m_lost = 0;
        end else begin
            if (!m_s2) begin
                if (m_run >= c_rel_run && m_lost < 255) m_lost++;
                m_run = 0;
            end else begin
                m_run++;
            end
            m_s2 = m_s1;
            m_s1 = pll_locked;
        end
        if (m_run >= c_rel_run) begin
            s = m_run - c_rel_run;
            m_ce_pix   = (s > 0) && (s % CE_DIV == 0);
            m_ce_pix_n = (s % CE_DIV == CE_DIV / 2);
            m_ce_cpu   = (s > 0) && (s % (2 * CE_DIV) == 0);
            m_ready    = (s >= c_ready_at);
        end else begin
            m_ce_pix = 0; m_ce_pix_n = 0; m_ce_cpu = 0; m_ready = 0;
        end
        m_core_reset = !m_ready;
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            chk("core_reset", core_reset, m_core_reset);
            chk("ready", ready, m_ready);
            chk("ce_pix", ce_pix, m_ce_pix);
            chk("ce_pix_n", ce_pix_n, m_ce_pix_n);
            chk("ce_cpu", ce_cpu, m_ce_cpu);
            chk("lock_lost_cnt", lock_lost_cnt, m_lost);
            chk("pix_pixn_overlap", ce_pix & ce_pix_n, 0);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Starts from WAIT_LOCK with the synchronized lock low; edge numbering is
    // relative to the call.
    task automatic lock_sequence(input bit lose_final, input int exp_lost);
        wait_neg(9);
        pll_locked = 1'b1;
        wait_neg(19);
        chk("rel28_core_reset", core_reset, 1);
        chk("rel28_ce_pix", ce_pix, 0);
        wait_neg(7);
        chk("e35_ce_pix", ce_pix, 0);
        wait_neg(1);
        chk("e36_ce_pix", ce_pix, 1);
        chk("e36_ce_cpu", ce_cpu, 0);
        chk("e36_model_ce_pix", m_ce_pix, 1);
        wait_neg(4);
        chk("e40_ce_pix_n", ce_pix_n, 1);
        wait_neg(4);
        chk("e44_ce_pix", ce_pix, 1);
        chk("e44_ce_cpu", ce_cpu, 1);
        if (lose_final) begin
            wait_neg(14);
            pll_locked = 1'b0;
            wait_neg(2);
            chk("e60_ce_pix", ce_pix, 1);
            chk("e60_core_reset", core_reset, 1);
            wait_neg(1);
            chk("e61_core_reset_held", core_reset, 1);
            chk("e61_ready_low", ready, 0);
            chk("e61_model_ready", m_ready, 0);
            chk("e61_lock_lost", lock_lost_cnt, exp_lost);
            wait_neg(8);
            chk("after_ready_low", ready, 0);
        end else begin
            wait_neg(16);
            chk("e60_ce_pix", ce_pix, 1);
            chk("e60_core_reset", core_reset, 1);
            wait_neg(1);
            chk("e61_core_reset", core_reset, 0);
            chk("e61_ready", ready, 1);
            chk("e61_model_ready", m_ready, 1);
            chk("e61_lock_lost", lock_lost_cnt, exp_lost);
        end
    endtask

    initial begin
        int n_pix, n_pixn, n_cpu, n_ovl;
        reset = 1'b1;
        pll_locked = 1'b0;
        wait_neg(3);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_ready", ready, 0);
        chk("rst_lock_lost", lock_lost_cnt, 0);
        chk("rst_state", 32'(dut.r_state), 32'(WAIT_LOCK));
        reset = 1'b0;

        lock_sequence(1'b0, 0);

        n_pix = 0; n_pixn = 0; n_cpu = 0; n_ovl = 0;
        for (int i = 0; i < 64; i++) begin
            wait_neg(1);
            n_pix  += int'(ce_pix);
            n_pixn += int'(ce_pix_n);
            n_cpu  += int'(ce_cpu);
            n_ovl  += int'(ce_cpu & ce_pix_n);
        end
        chk("run64_pix", n_pix, 8);
        chk("run64_pixn", n_pixn, 8);
        chk("run64_cpu", n_cpu, 4);
        chk("run64_cpu_pixn_ovl", n_ovl, 0);

        pll_locked = 1'b0;
        wait_neg(2);
        chk("loss_e1_core_reset", core_reset, 0);
        wait_neg(1);
        chk("loss_e2_core_reset", core_reset, 1);
        chk("loss_e2_ce_pix", ce_pix, 0);
        chk("loss_e2_lock_lost", lock_lost_cnt, 1);
        wait_neg(5);
        lock_sequence(1'b0, 1);

        reset = 1'b1;
        pll_locked = 1'b0;
        wait_neg(1);
        reset = 1'b0;
        pll_locked = 1'b1;
        wait_neg(10);
        pll_locked = 1'b0;
        wait_neg(1);
        pll_locked = 1'b1;
        wait_neg(11);
        chk("glitch_e22_core_reset", core_reset, 1);
        wait_neg(15);
        chk("glitch_e37_ce_pix", ce_pix, 0);
        wait_neg(1);
        chk("glitch_e38_ce_pix", ce_pix, 1);
        chk("glitch_e38_core_reset", core_reset, 1);

        reset = 1'b1;
        pll_locked = 1'b0;
        wait_neg(1);
        reset = 1'b0;
        lock_sequence(1'b1, 1);

        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            wait_neg(20);
            pll_locked = 1'b0;
            wait_neg(3);
        end
        chk("sat_lock_lost", lock_lost_cnt, 255);
        chk("sat_model_lost", m_lost, 255);

        pll_locked = 1'b1;
        reset = 1'b1;
        wait_neg(1);
        chk("sat_rst_lock_lost", lock_lost_cnt, 0);
        chk("sat_rst_core_reset", core_reset, 1);
        wait_neg(2);
        chk("sat_rst_state", 32'(dut.r_state), 32'(WAIT_LOCK));
        reset = 1'b0;
        wait_neg(2);
        chk("relock_e2_state", 32'(dut.r_state), 32'(WAIT_LOCK));
        wait_neg(1);
        chk("relock_e3_state", 32'(dut.r_state), 32'(STABILIZE));
        chk("relock_e3_core_reset", core_reset, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
